// File: rtl/stream_sink_if.sv
// Valid/ready stream bundle terminated by stream_sink.
// master = producer side, slave = sink side.
interface stream_sink_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_in_valid;
    logic             data_in_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready
    );
endinterface

// File: rtl/stream_sink.sv
// stream_sink: drains a valid/ready stream with programmable backpressure and
// checks the data against an incrementing sequence from a programmed seed.
// Optional build macro STREAM_SINK_PROTO_CHECK_EN adds proto_err_o, a sticky flag
// for valid/ready protocol violations seen while a run is in progress.
module stream_sink #(
    parameter int          WIDTH     = 8,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             srst,
    stream_sink_if.slave     sink,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_beats_i,
    input  logic [WIDTH-1:0] exp_seed_i,
    input  logic [1:0]       ready_mode_i,
    input  logic [3:0]       div_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] beat_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] first_err_o
`ifdef STREAM_SINK_PROTO_CHECK_EN
    ,
    output logic             proto_err_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        MODE_ALWAYS = 2'b00,
        MODE_NEVER  = 2'b01,
        MODE_LFSR   = 2'b10,
        MODE_DIV    = 2'b11
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ALL = '1;

    state_t           state;
    state_t           state_nxt;
    mode_t            mode_q;
    logic [CNT_W-1:0] num_q;
    logic [WIDTH-1:0] exp_q;
    logic [3:0]       div_q;
    logic [3:0]       div_cnt;
    logic [15:0]      lfsr;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_err;
    logic             ready_q;
    logic             ready_nxt;
    logic             mode_rdy;
    logic             start_run;
    logic             accept;
    logic             last_beat;
    logic             mismatch;

    // A start is only honoured outside RUN; during a run it is ignored.
    assign start_run = start_i && (state != RUN);
    assign accept    = (state == RUN) && sink.data_in_valid && ready_q;
    assign last_beat = accept && (num_q != '0) && ((beat_cnt + CNT_ONE) == num_q);
    assign mismatch  = (sink.data_in != exp_q);

    // Next-state and next-ready decision from the current pattern generators.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        mode_rdy  = 1'b0;
        unique case (state)
            IDLE:    if (start_run) state_nxt = RUN;
            RUN:     if (last_beat) state_nxt = DONE;
            DONE:    if (start_run) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        unique case (mode_q)
            MODE_ALWAYS: mode_rdy = 1'b1;
            MODE_NEVER:  mode_rdy = 1'b0;
            MODE_LFSR:   mode_rdy = lfsr[0];
            MODE_DIV:    mode_rdy = (div_cnt == 4'd0);
            default:     mode_rdy = 1'b0;
        endcase
        // Ready is decided during RUN and shows up the following cycle; it is
        // withheld when the current beat completes the run.
        ready_nxt = (state == RUN) && !last_beat && mode_rdy;
    end

    // State register, registered ready and the backpressure pattern generators.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (srst) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            lfsr    <= LFSR_SEED;
            div_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            ready_q <= ready_nxt;
            if (state == RUN) begin
                lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                div_cnt <= (div_cnt == div_q) ? 4'd0 : div_cnt + 4'd1;
            end else if (start_run) begin
                div_cnt <= 4'd0;
            end
        end
    end

    // Run configuration latched when a run begins.
    always_ff @(posedge clk_i) begin
        if (srst) begin
            mode_q <= MODE_ALWAYS;
            num_q  <= '0;
            div_q  <= 4'd0;
        end else if (start_run) begin
            mode_q <= mode_t'(ready_mode_i);
            num_q  <= num_beats_i;
            div_q  <= div_i;
        end
    end

    // Sequence checker and beat/error bookkeeping.
    always_ff @(posedge clk_i) begin
        if (srst) begin
            exp_q     <= '0;
            beat_cnt  <= '0;
            err_cnt   <= '0;
            first_err <= CNT_ALL;
        end else if (start_run) begin
            exp_q     <= exp_seed_i;
            beat_cnt  <= '0;
            err_cnt   <= '0;
            first_err <= CNT_ALL;
        end else if (accept) begin
            // The expected value advances on every accepted beat, good or bad.
            exp_q    <= exp_q + 1'b1;
            beat_cnt <= beat_cnt + CNT_ONE;
            if (mismatch) begin
                if (err_cnt != CNT_ALL) err_cnt <= err_cnt + CNT_ONE;
                if (first_err == CNT_ALL) first_err <= beat_cnt;
            end
        end
    end

    assign sink.data_in_ready = ready_q;
    assign busy_o             = (state == RUN);
    assign done_o             = (state == DONE);
    assign beat_cnt_o         = beat_cnt;
    assign err_cnt_o          = err_cnt;
    assign first_err_o        = first_err;

`ifdef STREAM_SINK_PROTO_CHECK_EN
    logic             stall_q;
    logic [WIDTH-1:0] data_q;
    logic             proto_err_q;

    // Snapshot of the previous cycle's data for the stall-stability check.
    always_ff @(posedge clk_i) begin
        // NOTE: data_q is only meaningful when stall_q is set, so it carries no reset.
        data_q <= sink.data_in;
    end

    // A stalled beat must keep valid high and data stable until it is taken.
    always_ff @(posedge clk_i) begin
        if (srst) begin
            stall_q     <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            stall_q <= (state == RUN) && sink.data_in_valid && !ready_q;
            if (start_run) begin
                proto_err_q <= 1'b0;
            end else if ((state == RUN) && stall_q &&
                         (!sink.data_in_valid || (sink.data_in != data_q))) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign proto_err_o = proto_err_q;
`endif

endmodule

// File: tb/tb_stream_sink.sv
// Self-checking bench for stream_sink: directed run sequence with randomized
// producer timing and data, checked every cycle against a behavioural model.
module tb_stream_sink;

    localparam int          WIDTH     = 8;
    localparam int          CNT_W     = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic             clk_i = 1'b0;
    logic             srst  = 1'b1;
    logic             start_i = 1'b0;
    logic [CNT_W-1:0] num_beats_i = '0;
    logic [WIDTH-1:0] exp_seed_i = '0;
    logic [1:0]       ready_mode_i = 2'b00;
    logic [3:0]       div_i = 4'd0;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] beat_cnt_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic [CNT_W-1:0] first_err_o;
`ifdef STREAM_SINK_PROTO_CHECK_EN
    logic             proto_err_o;
`endif

    always #5 clk_i = ~clk_i;

    stream_sink_if #(.WIDTH(WIDTH)) bus ();

    stream_sink #(
        .WIDTH    (WIDTH),
        .CNT_W    (CNT_W),
        .LFSR_SEED(LFSR_SEED)
    ) dut (
        .clk_i       (clk_i),
        .srst        (srst),
        .sink        (bus.slave),
        .start_i     (start_i),
        .num_beats_i (num_beats_i),
        .exp_seed_i  (exp_seed_i),
        .ready_mode_i(ready_mode_i),
        .div_i       (div_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .beat_cnt_o  (beat_cnt_o),
        .err_cnt_o   (err_cnt_o),
        .first_err_o (first_err_o)
`ifdef STREAM_SINK_PROTO_CHECK_EN
        ,
        .proto_err_o (proto_err_o)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model of the sink.
    bit          m_run, m_done, m_rdy;
    int          m_k, m_mode, m_div;
    logic [15:0] m_num, m_beats, m_errs, m_first, m_lfsr;
    logic [7:0]  m_exp;
    bit          m_perr, m_stall;
    logic [7:0]  m_pd;

    logic [7:0]  send_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Fibonacci LFSR, polynomial taps 16,14,13,11: feedback is the parity of those bits.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        int taps[4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[i]) fb ^= v[taps[i]-1];
        return {v[14:0], fb};
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".ready"}, bus.data_in_ready, m_rdy);
        check({tag, ".busy"},  busy_o,           m_run);
        check({tag, ".done"},  done_o,           m_done);
        check({tag, ".beats"}, beat_cnt_o,       m_beats);
        check({tag, ".errs"},  err_cnt_o,        m_errs);
        check({tag, ".first"}, first_err_o,      m_first);
`ifdef STREAM_SINK_PROTO_CHECK_EN
        check({tag, ".proto"}, proto_err_o,      m_perr);
`endif
    endtask

    // One clock cycle: drive inputs, advance the model, clock, compare.
    task automatic cycle(input logic st, input logic vld, input logic [7:0] d, output bit acc);
        bit last, nr;
        start_i = st;
        bus.data_in_valid = vld;
        bus.data_in = d;
        acc = m_run && vld && m_rdy;
`ifdef STREAM_SINK_PROTO_CHECK_EN
        if (m_run && m_stall && (!vld || d != m_pd)) m_perr = 1'b1;
        m_stall = m_run && vld && !m_rdy;
        m_pd = d;
        if (!m_run && st) m_perr = 1'b0;
`endif
        if (m_run) begin
            last = acc && (m_num != 16'd0) && ((m_beats + 16'd1) == m_num);
            case (m_mode)
                0:       nr = 1'b1;
                1:       nr = 1'b0;
                2:       nr = m_lfsr[0];
                default: nr = ((m_k % (m_div + 1)) == 0);
            endcase
            m_lfsr = lfsr_next(m_lfsr);
            m_k++;
            if (acc) begin
                if (d != m_exp) begin
                    if (m_errs != 16'hFFFF) m_errs++;
                    if (m_first == 16'hFFFF) m_first = m_beats;
                end
                m_beats++;
                m_exp++;
            end
            m_rdy = nr && !last;
            if (last) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end else if (st) begin
            m_run   = 1'b1;
            m_done  = 1'b0;
            m_rdy   = 1'b0;
            m_k     = 0;
            m_num   = num_beats_i;
            m_exp   = exp_seed_i;
            m_mode  = int'(ready_mode_i);
            m_div   = int'(div_i);
            m_beats = 16'd0;
            m_errs  = 16'd0;
            m_first = 16'hFFFF;
        end
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        check_outputs("cyc");
    endtask

    task automatic do_reset();
        srst = 1'b1;
        start_i = 1'b0;
        bus.data_in_valid = 1'b0;
        @(posedge clk_i);
        #1;
        srst = 1'b0;
        m_run = 0; m_done = 0; m_rdy = 0; m_k = 0;
        m_beats = 16'd0; m_errs = 16'd0; m_first = 16'hFFFF;
        m_lfsr = LFSR_SEED; m_perr = 0; m_stall = 0; m_pd = 8'h00;
        check_outputs("reset");
    endtask

    task automatic begin_run(input int num, input logic [7:0] seed, input int mode, input int dv);
        bit acc;
        num_beats_i  = 16'(num);
        exp_seed_i   = seed;
        ready_mode_i = 2'(mode);
        div_i        = 4'(dv);
        cycle(1'b1, 1'b0, 8'h00, acc);
    endtask

    // Producer: offers send_q in order with random valid gaps, holding each beat until taken.
    task automatic feed(input int max_cycles, input int vld_pct, input int stop_beats,
                        output int n_cyc, output int n_rdy);
        bit acc, vld;
        logic [7:0] d;
        n_cyc = 0;
        n_rdy = 0;
        while (m_run && send_q.size() > 0 && n_cyc < max_cycles && int'(m_beats) < stop_beats) begin
            vld = ($urandom_range(99) < vld_pct);
            d = vld ? send_q[0] : 8'($urandom);
            if (bus.data_in_ready) n_rdy++;
            cycle(1'b0, vld, d, acc);
            if (acc) void'(send_q.pop_front());
            n_cyc++;
        end
    endtask

    initial begin
        bit acc;
        int n, r;
        bus.data_in = 8'h00;
        bus.data_in_valid = 1'b0;

        // Reset state.
        do_reset();

        // Mode 00, seed 10, five back-to-back beats.
        begin_run(5, 8'h10, 0, 0);
        send_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        feed(40, 100, 1000, n, r);
        check("t1.done", done_o, 1'b1);
        check("t1.beats", beat_cnt_o, 16'd5);
        check("t1.errs", err_cnt_o, 16'd0);
        check("t1.first", first_err_o, 16'hFFFF);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h15, acc);
        check("t1.ready_after", bus.data_in_ready, 1'b0);

        // Sequence wrap FE,FF,00,01 is clean.
        begin_run(4, 8'hFE, 0, 0);
        send_q = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        feed(40, 100, 1000, n, r);
        check("t2.errs", err_cnt_o, 16'd0);
        check("t2.beats", beat_cnt_o, 16'd4);

        // One bad beat at index 2.
        begin_run(4, 8'hFE, 0, 0);
        send_q = '{8'hFE, 8'hFF, 8'h02, 8'h01};
        feed(40, 60, 1000, n, r);
        check("t2b.errs", err_cnt_o, 16'd1);
        check("t2b.first", first_err_o, 16'd2);

        // Mode 11, div 3: one ready cycle in four, 8 beats in about 32 cycles.
        begin_run(8, 8'h40, 3, 3);
        send_q = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
        feed(100, 100, 1000, n, r);
        check("t3.done", done_o, 1'b1);
        check("t3.ready_cycles", 32'(r), 32'd8);
        check("t3.duration_ok", 32'((n + 1) >= 31 && (n + 1) <= 33), 32'd1);

        // Mode 10 from a fresh LFSR, 100 beats with a few corrupted values.
        do_reset();
        begin_run(100, 8'h00, 2, 0);
        for (int i = 0; i < 100; i++)
            send_q.push_back(($urandom_range(99) < 5) ? 8'(i + 1 + $urandom_range(200)) : 8'(i));
        feed(3000, 70, 1000, n, r);
        check("t4.done", done_o, 1'b1);
        check("t4.beats", beat_cnt_o, 16'd100);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'd100, acc);
        check("t4.no_extra", beat_cnt_o, 16'd100);

        // Reset in the middle of a run, then a clean run with an ignored start.
        begin_run(10, 8'h20, 0, 0);
        send_q.delete();
        for (int i = 0; i < 10; i++) send_q.push_back(8'(8'h20 + i));
        feed(100, 100, 3, n, r);
        check("t5.mid_beats", beat_cnt_o, 16'd3);
        do_reset();
        begin_run(6, 8'h80, 3, 0);
        send_q.delete();
        for (int i = 0; i < 6; i++) send_q.push_back(8'(8'h80 + i));
        feed(100, 100, 2, n, r);
        num_beats_i = 16'd2;
        ready_mode_i = 2'b01;
        cycle(1'b1, 1'b1, send_q[0], acc);
        if (acc) void'(send_q.pop_front());
        feed(100, 100, 1000, n, r);
        check("t5.done", done_o, 1'b1);
        check("t5.beats", beat_cnt_o, 16'd6);

        // Unbounded run: keeps going, corrupted values counted.
        begin_run(0, 8'hF0, 0, 0);
        send_q.delete();
        for (int i = 0; i < 40; i++) send_q.push_back((i % 7 == 3) ? 8'(8'hF0 + i + 9) : 8'(8'hF0 + i));
        feed(200, 80, 1000, n, r);
        check("t6.busy", busy_o, 1'b1);
        check("t6.beats", beat_cnt_o, 16'd40);
        check("t6.errs", err_cnt_o, 16'd6);
        check("t6.first", first_err_o, 16'd3);

`ifdef STREAM_SINK_PROTO_CHECK_EN
        // Data changed while stalled in mode 01.
        do_reset();
        begin_run(4, 8'h00, 1, 0);
        cycle(1'b0, 1'b1, 8'hA5, acc);
        cycle(1'b0, 1'b1, 8'hA5, acc);
        check("t7.before", proto_err_o, 1'b0);
        cycle(1'b0, 1'b1, 8'h5A, acc);
        check("t7.set", proto_err_o, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h5A, acc);
        check("t7.sticky", proto_err_o, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_sink.md
Name: stream_sink

Overview:
- Receiving end of the team's valid/ready data stream.
- Terminates the output of a `pipeline` instance (or any valid/ready producer) and drives `data_in_ready` with a programmable backpressure pattern.
- Checks that received data follows an incrementing sequence from a programmed seed, and counts beats and mismatches.
- Used in benches and in on-chip self-test paths to drain and verify streams.

Parameters:
- WIDTH, 8, data bus width in bits.
- CNT_W, 16, width of the beat/error counters and of `num_beats_i`.
- LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit backpressure LFSR.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- srst  in  1  synchronous reset, active-high.
- data_in  in  WIDTH  stream data.
- data_in_valid  in  1  stream valid.
- data_in_ready  out  1  stream ready (backpressure).
- start_i  in  1  one-cycle pulse; begins a run.
- num_beats_i  in  CNT_W  beats to accept in the run; 0 = unbounded.
- exp_seed_i  in  WIDTH  expected value of the first beat.
- ready_mode_i  in  2  00 always ready, 01 never ready, 10 LFSR random, 11 ready one cycle in every (div_i+1).
- div_i  in  4  divider for mode 11.
- busy_o  out  1  run in progress.
- done_o  out  1  run complete (sticky until next start or reset).
- beat_cnt_o  out  CNT_W  beats accepted this run.
- err_cnt_o  out  CNT_W  data mismatches this run; saturates at all-ones.
- first_err_o  out  CNT_W  beat index of the first mismatch; all-ones if none.

Behaviour:
- Reset (srst high at a rising edge): state IDLE, data_in_ready=0, busy_o=0, done_o=0, beat_cnt_o=0, err_cnt_o=0, first_err_o=all-ones, LFSR=LFSR_SEED, divider counter=0. srst has priority over every other input; a reset mid-run aborts the run without setting done_o.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start_i--> RUN. On entry: latch num_beats_i, exp_seed_i, ready_mode_i, div_i; clear all counters; set first_err_o to all-ones; done_o=0.
  - RUN --last beat accepted--> DONE. "Last beat" means beat_cnt reaches the latched num_beats, and num_beats != 0.
  - DONE: done_o=1 and data_in_ready=0. start_i returns to RUN (restart).
  - start_i during RUN is ignored.
- Handshake: a beat is accepted in any cycle where data_in_valid && data_in_ready, in state RUN only. data_in_ready is 0 outside RUN.
- data_in_ready is registered (asserted one cycle after the mode decision). It never depends combinationally on data_in_valid.
- Mode 10: the 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every RUN cycle; ready = LFSR bit 0.
- Mode 11: a 4-bit counter wraps at div_i; ready is high when the counter is 0. div_i=0 gives always ready.
- Ready must drop in the same cycle the last beat is accepted, so no extra beat is taken.
- Check: expected value starts at exp_seed and increments by 1 (mod 2^WIDTH) per accepted beat, including on a mismatch. 8'hFF is followed by 8'h00.
  - On mismatch: err_cnt increments, saturating.
  - first_err_o captures the current beat_cnt only while it is still all-ones.
- beat_cnt wraps modulo 2^CNT_W in unbounded mode.
- busy_o = (state == RUN).
- Latency: none on data; counters update the cycle after acceptance.

Optional Feature:
- Macro: STREAM_SINK_PROTO_CHECK_EN.
- Defined:
  - Adds output `proto_err_o` (1 bit, reset 0, sticky until start_i or srst).
  - Sets on a valid/ready protocol violation during RUN: data_in_valid high and data_in_ready low in cycle N, then in cycle N+1 either data_in_valid drops or data_in changes.
- Not defined: the port and its logic are absent, and the block is otherwise identical.

Test Plan:
- Mode 00, seed 8'h10, num_beats 5, producer sends 10..14 back-to-back -> done_o after the 5th beat, beat_cnt_o=5, err_cnt_o=0, first_err_o=16'hFFFF, data_in_ready=0 afterwards.
- Mode 00, seed 8'hFE, 4 beats FE,FF,00,01 -> err_cnt_o=0 (wrap-around); sending FE,FF,02,01 instead -> err_cnt_o=1, first_err_o=2.
- Mode 11, div_i=3, producer always valid -> data_in_ready high exactly 1 cycle in 4; 8 beats take 32 cycles ±1.
- Mode 10, 100 beats -> data_in_ready matches the golden LFSR model bit-for-bit; all beats counted; no beat accepted after done_o.
- srst asserted mid-run (beat 3 of 10) -> next cycle busy_o=0, done_o=0, counters 0, data_in_ready=0; a new start_i runs cleanly.
- With STREAM_SINK_PROTO_CHECK_EN: mode 01, valid held, data changed while stalled -> proto_err_o=1 the following cycle and stays set.
